// File: rtl/lnrv_mem_loader.sv
// lnrv_mem_loader: packs a byte stream little-endian into RAM words and holds the core in reset until the image is loaded.
// Ports: clk/reset (sync, active-high); start + byte_len begin a load at word 0;
//   s_valid/s_ready/s_data byte stream; ram_cs/ram_we/ram_wem/ram_addr/ram_wdata RAM write port;
//   busy (LOAD/FLUSH/HOLD), done (RUN), err (sticky overflow), cpu_reset_n (active-low core reset).
// Define LNRV_MEM_LOADER_CHKSUM_EN to add chksum[31:0], the wrapping sum of all accepted bytes.
module lnrv_mem_loader #(
  parameter int P_ADDR_WIDTH = 16,
  parameter int P_DATA_WIDTH = 32,
  parameter int P_LEN_WIDTH  = 24,
  parameter int P_RST_DELAY  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [P_LEN_WIDTH-1:0]    byte_len,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [7:0]                s_data,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic [P_DATA_WIDTH/8-1:0] ram_wem,
  output logic [P_ADDR_WIDTH-1:0]   ram_addr,
  output logic [P_DATA_WIDTH-1:0]   ram_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
`ifdef LNRV_MEM_LOADER_CHKSUM_EN
  output logic [31:0]               chksum,
`endif
  output logic                      cpu_reset_n
);
  localparam int NB = P_DATA_WIDTH / 8;
  localparam int LW = NB > 1 ? $clog2(NB) : 1;
  localparam int DW = P_RST_DELAY > 1 ? $clog2(P_RST_DELAY) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, HOLD, RUN} state_t;
  state_t state_q, state_d;
  logic [P_LEN_WIDTH-1:0] len_q, cnt_q;
  logic [LW-1:0] lane_q;
  logic [NB-1:0] mask_q, mask_m, ram_wem_q;
  logic [P_DATA_WIDTH-1:0] pack_q, pack_m, ram_wdata_q;
  // one extra bit so reaching 2**P_ADDR_WIDTH is visible instead of wrapping to 0
  logic [P_ADDR_WIDTH:0] addr_q;
  logic [P_ADDR_WIDTH-1:0] ram_addr_q;
  logic [DW-1:0] dly_q;
  logic s_ready_q, ram_cs_q, busy_q, done_q, err_q, cpu_rst_n_q;
  logic [31:0] chksum_q;
  logic go, acc, last, wr, ovf;
  always_comb begin
    go = start && (state_q == IDLE || state_q == RUN);
    acc = state_q == LOAD && s_ready_q && s_valid;
    last = cnt_q + P_LEN_WIDTH'(1) == len_q;
    wr = acc && (lane_q == LW'(NB - 1) || last);
    ovf = addr_q[P_ADDR_WIDTH];
    pack_m = pack_q;
    mask_m = mask_q;
    for (int i = 0; i < NB; i++)
      if (lane_q == LW'(i)) begin
        pack_m[i*8 +: 8] = s_data;
        mask_m[i] = 1'b1;
      end
    state_d = go ? (byte_len != '0 ? LOAD : HOLD) :
              (acc && last) ? FLUSH :
              state_q == FLUSH ? HOLD :
              (state_q == HOLD && dly_q == DW'(P_RST_DELAY - 1)) ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      lane_q <= '0;
      mask_q <= '0;
      pack_q <= '0;
      addr_q <= '0;
      dly_q <= '0;
      s_ready_q <= 1'b0;
      ram_cs_q <= 1'b0;
      ram_wem_q <= '0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      chksum_q <= '0;
    end else begin
      state_q <= state_d;
      s_ready_q <= state_d == LOAD;
      busy_q <= state_d inside {LOAD, FLUSH, HOLD};
      done_q <= state_d == RUN;
      cpu_rst_n_q <= state_d == RUN;
      dly_q <= state_q == HOLD ? dly_q + DW'(1) : '0;
      ram_cs_q <= wr && !ovf;
      ram_wem_q <= (wr && !ovf) ? mask_m : '0;
      ram_wdata_q <= (wr && !ovf) ? pack_m : '0;
      if (wr && !ovf) ram_addr_q <= addr_q[P_ADDR_WIDTH-1:0];
      if (go) begin
        len_q <= byte_len;
        cnt_q <= '0;
        lane_q <= '0;
        mask_q <= '0;
        pack_q <= '0;
        addr_q <= '0;
        err_q <= 1'b0;
        chksum_q <= '0;
      end else if (acc) begin
        cnt_q <= cnt_q + P_LEN_WIDTH'(1);
        chksum_q <= chksum_q + 32'(s_data);
        lane_q <= wr ? '0 : lane_q + LW'(1);
        mask_q <= wr ? '0 : mask_m;
        pack_q <= wr ? '0 : pack_m;
        // once past the top word the address saturates; later words are dropped
        if (wr) addr_q <= ovf ? addr_q : addr_q + (P_ADDR_WIDTH + 1)'(1);
        if (wr && ovf) err_q <= 1'b1;
      end
    end
  end
  assign s_ready = s_ready_q;
  assign ram_cs = ram_cs_q;
  assign ram_we = ram_cs_q;
  assign ram_wem = ram_wem_q;
  assign ram_addr = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign cpu_reset_n = cpu_rst_n_q;
`ifdef LNRV_MEM_LOADER_CHKSUM_EN
  assign chksum = chksum_q;
`else
  logic unused_chk;
  assign unused_chk = ^chksum_q;
`endif
endmodule
